// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: datapath width, RV32M funct3 encodings and the
// multiply/divide sequencer state enum.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StPrep,
    StCalc,
    StFin
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_abs_sign.sv
// Conditional two's-complement negation: magnitude of a signed operand, or a
// forced negation when applying a recorded result sign.
module muldiv_abs_sign #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] value,
  input  logic         is_signed,
  input  logic         force_neg,
  output logic [W-1:0] magnitude
);

  logic neg;

  assign neg       = (is_signed & value[W-1]) | force_neg;
  assign magnitude = neg ? ({W{1'b0}} - value) : value;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// division on operand magnitudes, one bit per cycle, sign fixed up at the end.
module muldiv_sequencer
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] in_1,
  input  logic [XLEN-1:0] in_2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result_out,
  output logic            div_zero
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] m_q, m_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic            neg_q, neg_d;
  logic            dz_q, dz_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            div_zero_q, div_zero_d;

  logic is_div, is_rem, a_signed, b_signed, sign_a, sign_b, accept;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, fin_val, fin_mag;

  assign is_div   = op_q[2];
  assign is_rem   = op_q[2] & op_q[1];
  assign a_signed = (op_q == F3_MUL) | (op_q == F3_MULH) | (op_q == F3_MULHSU) |
                    (op_q == F3_DIV) | (op_q == F3_REM);
  assign b_signed = (op_q == F3_MUL) | (op_q == F3_MULH) | (op_q == F3_DIV) |
                    (op_q == F3_REM);
  assign sign_a   = a_signed & opa_q[XLEN-1];
  assign sign_b   = b_signed & opb_q[XLEN-1];

  muldiv_abs_sign #(.W(XLEN)) u_abs_a (
    .value     (opa_q),
    .is_signed (a_signed),
    .force_neg (1'b0),
    .magnitude (mag_a)
  );

  muldiv_abs_sign #(.W(XLEN)) u_abs_b (
    .value     (opb_q),
    .is_signed (b_signed),
    .force_neg (1'b0),
    .magnitude (mag_b)
  );

  // Multiply: acc = {partial product high, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, m_q};
  assign div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  // Full-width negation so MULH* see the correct high word of a negative product.
  assign fin_val = !is_div ? acc_q
                 : {{XLEN{1'b0}}, (is_rem ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0])};

  muldiv_abs_sign #(.W(2*XLEN)) u_fin_neg (
    .value     (fin_val),
    .is_signed (1'b0),
    .force_neg (neg_q),
    .magnitude (fin_mag)
  );

  assign busy   = (state_q != StIdle) | done_q;
  assign accept = start & ~busy & ~flush;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    m_d        = m_q;
    acc_d      = acc_q;
    neg_d      = neg_q;
    dz_d       = dz_q;
    done_d     = 1'b0;
    result_d   = result_q;
    div_zero_d = div_zero_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d    = funct3;
          opa_d   = in_1;
          opb_d   = in_2;
          state_d = StPrep;
        end
      end
      StPrep: begin
        neg_d = is_rem ? sign_a : (sign_a ^ sign_b);
        dz_d  = 1'b0;
        cnt_d = '0;
        if (is_div && (opb_q == '0)) begin
          acc_d   = {opa_q, {XLEN{1'b1}}};
          neg_d   = 1'b0;
          dz_d    = 1'b1;
          state_d = StFin;
        end else if (is_div && !op_q[0] && (opa_q == MinNeg) && (opb_q == '1)) begin
          acc_d   = {{XLEN{1'b0}}, MinNeg};
          neg_d   = 1'b0;
          state_d = StFin;
        end else if (is_div) begin
          m_d     = mag_b;
          acc_d   = {{XLEN{1'b0}}, mag_a};
          state_d = StCalc;
        end else begin
          m_d     = mag_a;
          acc_d   = {{XLEN{1'b0}}, mag_b};
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d = is_div ? div_next : mul_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(XLEN - 1)) begin
          state_d = StFin;
        end
      end
      StFin: begin
        if (op_q == F3_MUL || is_div) begin
          result_d = fin_mag[XLEN-1:0];
        end else begin
          result_d = fin_mag[2*XLEN-1:XLEN];
        end
        div_zero_d = dz_q;
        done_d     = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (flush && (state_q != StIdle)) begin
      state_d    = StIdle;
      done_d     = 1'b0;
      result_d   = result_q;
      div_zero_d = div_zero_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      m_q        <= '0;
      acc_q      <= '0;
      neg_q      <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      m_q        <= m_d;
      acc_q      <= acc_d;
      neg_q      <= neg_d;
      dz_q       <= dz_d;
      done_q     <= done_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign done       = done_q;
  assign result_out = result_q;
  assign div_zero   = div_zero_q;

endmodule
